// File: rtl/tanh_q17_pkg.sv
// Shared Q1.7 tanh definitions: sample type, table geometry and the
// positive-half magnitude of the forward table (x = k/8, trunc(128*tanh(x))).
package tanh_q17_pkg;

  typedef logic signed [7:0] q17_t;

  localparam int unsigned TANH_LUT_DEPTH = 96;
  localparam int unsigned TANH_ZERO_IDX  = 48;
  localparam q17_t        TANH_Q17_MAX   = 8'sh7F;
  localparam q17_t        TANH_Q17_MIN   = 8'sh81;

  // Magnitude for distance k from the zero index; saturates from k = 23.
  function automatic q17_t tanh_mag(input logic [7:0] k);
    case (k)
      8'd0:    tanh_mag = 8'sd0;
      8'd1:    tanh_mag = 8'sd15;
      8'd2:    tanh_mag = 8'sd31;
      8'd3:    tanh_mag = 8'sd45;
      8'd4:    tanh_mag = 8'sd59;
      8'd5:    tanh_mag = 8'sd70;
      8'd6:    tanh_mag = 8'sd81;
      8'd7:    tanh_mag = 8'sd90;
      8'd8:    tanh_mag = 8'sd97;
      8'd9:    tanh_mag = 8'sd103;
      8'd10:   tanh_mag = 8'sd108;
      8'd11:   tanh_mag = 8'sd112;
      8'd12:   tanh_mag = 8'sd115;
      8'd13:   tanh_mag = 8'sd118;
      8'd14:   tanh_mag = 8'sd120;
      8'd15:   tanh_mag = 8'sd122;
      8'd16:   tanh_mag = 8'sd123;
      8'd17:   tanh_mag = 8'sd124;
      8'd18:   tanh_mag = 8'sd125;
      8'd19:   tanh_mag = 8'sd125;
      8'd20:   tanh_mag = 8'sd126;
      8'd21:   tanh_mag = 8'sd126;
      8'd22:   tanh_mag = 8'sd126;
      default: tanh_mag = TANH_Q17_MAX;
    endcase
  endfunction

endpackage

// File: rtl/tanh_1_7_inv_search_if.sv
// Request/response handshake bundle for the inverse tanh search.
interface tanh_1_7_inv_search_if #(
  parameter int unsigned IDX_W = 7
);

  logic                    in_valid;
  logic                    in_ready;
  tanh_q17_pkg::q17_t      in_value;
  logic                    out_valid;
  logic                    out_ready;
  logic [IDX_W-1:0]        out_index;
  logic                    out_exact;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_index, out_exact
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_index, out_exact
  );

endinterface

// File: rtl/tanh_1_7_lut.sv
// Forward Q1.7 tanh table, odd-symmetric around TANH_ZERO_IDX; addresses
// beyond the valid depth read as the positive rail.
module tanh_1_7_lut
  import tanh_q17_pkg::*;
(
  input  logic [7:0] addr,
  output q17_t       data_c
);

  logic       neg_c;
  logic [7:0] dist_c;
  q17_t       mag_c;

  always_comb begin
    neg_c  = addr < 8'(TANH_ZERO_IDX);
    dist_c = neg_c ? (8'(TANH_ZERO_IDX) - addr) : (addr - 8'(TANH_ZERO_IDX));
    mag_c  = tanh_mag(dist_c);
    if (addr >= 8'(TANH_LUT_DEPTH)) begin
      data_c = TANH_Q17_MAX;
    end else if (neg_c) begin
      data_c = (mag_c == TANH_Q17_MAX) ? TANH_Q17_MIN : -mag_c;
    end else begin
      data_c = mag_c;
    end
  end

endmodule

// File: rtl/tanh_1_7_inv_search.sv
// Sequential binary search over the forward tanh table: returns the lowest
// index whose entry is >= the target, plus an exact-hit flag.
module tanh_1_7_inv_search
  import tanh_q17_pkg::*;
#(
  parameter int unsigned DEPTH  = TANH_LUT_DEPTH,
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned N_ITER = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tanh_1_7_inv_search_if.slave    bus
);

  localparam int unsigned STEP_W = $clog2(N_ITER + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  logic [1:0]        state_q,     state_d;
  q17_t              target_q,    target_d;
  logic [IDX_W-1:0]  lo_q,        lo_d;
  logic [IDX_W-1:0]  hi_q,        hi_d;
  logic [STEP_W-1:0] step_q,      step_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic              out_exact_q, out_exact_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q,  in_ready_d;

  logic [IDX_W:0]    sum_c;
  logic [IDX_W-1:0]  mid_c;
  logic [7:0]        lut_addr_c;
  q17_t              lut_data_c;

  tanh_1_7_lut u_lut (
    .addr   (lut_addr_c),
    .data_c (lut_data_c)
  );

  // Single table port: probe mid while searching, re-read lo for the exact check.
  always_comb begin
    sum_c      = {1'b0, lo_q} + {1'b0, hi_q};
    mid_c      = IDX_W'(sum_c >> 1);
    lut_addr_c = (state_q == S_CHECK) ? 8'(lo_q) : 8'(mid_c);
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    step_d      = step_q;
    out_index_d = out_index_q;
    out_exact_d = out_exact_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          target_d = bus.in_value;
          lo_d     = '0;
          hi_d     = IDX_W'(DEPTH - 1);
          step_d   = '0;
          state_d  = S_SEARCH;
        end
      end
      S_SEARCH: begin
        // Fixed step count keeps latency data-independent; converged ranges just hold.
        if (lo_q < hi_q) begin
          if (lut_data_c >= target_q) hi_d = mid_c;
          else                        lo_d = mid_c + IDX_W'(1);
        end
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(N_ITER - 1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        out_index_d = lo_q;
        out_exact_d = (lut_data_c == target_q);
        state_d     = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      step_q      <= '0;
      out_index_q <= '0;
      out_exact_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      step_q      <= step_d;
      out_index_q <= out_index_d;
      out_exact_q <= out_exact_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.out_exact = out_exact_q;

endmodule

// File: tb/tb_tanh_1_7_inv_search.sv
// Bench for tanh_1_7_inv_search: directed table vectors, backpressure and
// mid-search reset sequences, and random targets against a tanh-derived model.
module tb_tanh_1_7_inv_search;
  import tanh_q17_pkg::*;

  localparam int unsigned IDX_W = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tanh_1_7_inv_search_if #(.IDX_W(IDX_W)) bus ();

  tanh_1_7_inv_search #(.DEPTH(96), .IDX_W(IDX_W), .N_ITER(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ref_tbl [96];

  typedef struct {
    logic [7:0] val;
    int         idx;
    int         exact;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_index(input logic [7:0] v);
    int sv = int'($signed(v));
    for (int i = 0; i < 96; i++) if (ref_tbl[i] >= sv) return i;
    return -1;
  endfunction

  // One full transaction; out_ready held low for 'stall' cycles after out_valid rises.
  task automatic send(input logic [7:0] v, input int stall,
                      output int lat, output int idx, output int ex);
    int guard = 0;
    int cyc;
    lat = -1;
    while (!bus.in_ready && guard < 30) begin
      @(posedge clk); #1; guard++;
    end
    chk("in_ready_before_req", int'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.in_value  = v;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 30) begin
      @(posedge clk); #1; cyc++;
    end
    if (bus.out_valid) lat = cyc;
    idx = int'(bus.out_index);
    ex  = int'(bus.out_exact);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_hold", int'({bus.out_valid, bus.in_ready, bus.out_index, bus.out_exact}),
          int'({1'b1, 1'b0, 7'(idx), 1'(ex)}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_handshake", int'({bus.out_valid, bus.in_ready}), int'(2'b01));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, idx, ex, seen, cyc, ridx;
    logic [7:0] v;

    for (int i = 0; i < 96; i++)
      ref_tbl[i] = $rtoi(128.0 * $tanh(real'(i - 48) / 8.0));

    vecs[0] = '{8'h00, 48, 1};
    vecs[1] = '{8'h01, 49, 0};
    vecs[2] = '{8'h0F, 49, 1};
    vecs[3] = '{8'h7F, 71, 1};
    vecs[4] = '{8'h7E, 68, 1};
    vecs[5] = '{8'h80, 0, 0};
    vecs[6] = '{8'h81, 0, 1};

    bus.in_valid  = 1'b0;
    bus.in_value  = 8'h00;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_state", int'({bus.out_valid, bus.in_ready, bus.out_index, bus.out_exact}),
        int'({1'b0, 1'b1, 7'd0, 1'b0}));

    // Directed vectors
    foreach (vecs[i]) begin
      send(vecs[i].val, 0, lat, idx, ex);
      chk($sformatf("vec%0d_latency", i), lat, 9);
      chk($sformatf("vec%0d_index", i), idx, vecs[i].idx);
      chk($sformatf("vec%0d_exact", i), ex, vecs[i].exact);
    end

    // Backpressure with an ignored in_valid pulse during the stall
    bus.in_valid  = 1'b1;
    bus.in_value  = 8'h3B;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 30) begin
      @(posedge clk); #1; cyc++;
    end
    chk("bp_latency", bus.out_valid ? cyc : -1, 9);
    chk("bp_index", int'(bus.out_index), 52);
    chk("bp_exact", int'(bus.out_exact), 1);
    for (int s = 0; s < 5; s++) begin
      bus.in_valid = (s == 1);
      bus.in_value = (s == 1) ? 8'h80 : 8'h3B;
      @(posedge clk); #1;
      chk("bp_hold", int'({bus.out_valid, bus.in_ready, bus.out_index, bus.out_exact}),
          int'({1'b1, 1'b0, 7'd52, 1'b1}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", int'({bus.out_valid, bus.in_ready}), int'(2'b01));
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    chk("bp_pulse_ignored", seen, 0);

    // Reset during SEARCH cycle 4 discards the request
    bus.in_valid = 1'b1;
    bus.in_value = 8'h25;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    chk("rst_discarded", seen, 0);
    send(8'hE1, 0, lat, idx, ex);
    chk("after_rst_latency", lat, 9);
    chk("after_rst_index", idx, 46);
    chk("after_rst_exact", ex, 1);

    // Random targets against the tanh model
    for (int n = 0; n < 40; n++) begin
      v = 8'($urandom_range(0, 255));
      send(v, int'($urandom_range(0, 3)), lat, idx, ex);
      ridx = ref_index(v);
      chk($sformatf("rnd%0d_latency", n), lat, 9);
      chk($sformatf("rnd%0d_index_v%0h", n, v), idx, ridx);
      chk($sformatf("rnd%0d_exact_v%0h", n, v), ex,
          (ridx >= 0 && ref_tbl[ridx] == int'($signed(v))) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
